acia_arbiter: RTL
=================

// Module: acia_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the single ACIA register port.
//  Lets the 65C02 bus (A) and a secondary master (B, e.g. boot loader/monitor) share it.
//  Turns each req/ack transaction into exactly one ACIA rd or wr strobe and returns read data.
//  Sits between the bus decode/masters and the acia instance.
// PARAMETERS
//  FIXED_PRIO  0  0 = round-robin between A and B; 1 = A always wins a tie
//  GAP         0  idle cycles inserted after each completed transaction (0..15)
// PORTS
//  clk         in   1  system clock; all logic on posedge
//  reset       in   1  synchronous, active-high reset
//  a_req       in   1  requester A transaction request; held until a_ack
//  a_wr        in   1  A: 1 = write, 0 = read; stable while a_req
//  a_regSel    in   2  A: ACIA register select; stable while a_req
//  a_wdata     in   8  A: write data; stable while a_req
//  a_ack       out  1  A: one-cycle completion pulse
//  a_rdata     out  8  A: read data; valid with a_ack, held until next A read
//  b_req/b_wr/b_regSel/b_wdata/b_ack/b_rdata  same as A, for requester B
//  acia_rd     out  1  to acia rd
//  acia_wr     out  1  to acia wr
//  acia_regSel out  2  to acia regSel
//  acia_dataIn out  8  to acia dataIn
//  acia_dataOut in  8  from acia dataOut; registered, valid the cycle after acia_rd
// BEHAVIOUR
//  - Reset: state IDLE; all acks, acia_rd, acia_wr = 0; acia_regSel = 0; acia_dataIn = 0;
//    a_rdata = b_rdata = 0; last-grant = B; gap counter = 0.
//  - Reset mid-transaction: abort to IDLE; no ack issued; strobes low the next cycle.
//  - ACIA outputs decode from state + latched command only; no comb path from req inputs.
//  - FSM:
//    IDLE:  sample reqs. None -> IDLE. One -> grant it. Both -> FIXED_PRIO=1: A;
//           else the one not granted last. Latch wr/regSel/wdata, update last-grant -> ISSUE.
//    ISSUE: exactly one cycle of acia_rd (read) or acia_wr (write) with latched regSel/data -> DONE.
//    DONE:  pulse winner's ack; for reads load winner's rdata from acia_dataOut
//           (writes leave rdata unchanged) -> GAP if GAP>0, else IDLE.
//    GAP:   count GAP cycles, strobes low -> IDLE.
//  - Latency: req high at IDLE edge -> ISSUE next cycle -> ack in the following cycle
//    (3 cycles req-to-ack, GAP=0, no contention). Back-to-back throughput: 1 txn / (3+GAP) cycles.
//  - Requester rule: drop req on the edge where ack is seen; the next IDLE then sees req low.
//    Req still high in IDLE is a new transaction.
//  - Round-robin: both held continuously -> strict alternation A,B,A,B... starting with A after reset.
//  - regSel 2/3: strobe still issued (ACIA ignores it); read returns current acia_dataOut unchanged.
//  - Loser's req is ignored until the arbiter returns to IDLE; it is never dropped.
//  - Never assert acia_rd and acia_wr in the same cycle.
// CONFIGURATION
//  ACIA_ARB_TXWAIT_EN defined: writes to regSel 0 first pass through POLL
//    (one-cycle acia_rd, regSel=1) then PCHK: if acia_dataOut[1] (TX not full) = 1 -> ISSUE write;
//    else -> POLL again, indefinitely. Status reads do not touch the requester's rdata.
//    Reset exits POLL/PCHK to IDLE.
//  Not defined: POLL/PCHK absent; writes go IDLE->ISSUE directly. A write to a full TX FIFO
//    is issued and lost (ACIA behaviour).
// TESTING
//  1 A read regSel=1 alone, acia_dataOut=8'h03 after strobe -> one acia_rd cycle, a_ack 3 cycles
//    after req, a_rdata=8'h03, b_ack never high.
//  2 A and B both req continuously, 6 txns -> grant order A,B,A,B,A,B; with FIXED_PRIO=1 -> A only
//    while a_req held.
//  3 B write regSel=0 data 8'h41 -> acia_wr 1 cycle, acia_dataIn=8'h41, acia_regSel=0, b_ack, b_rdata unchanged.
//  4 GAP=3, back-to-back A reads -> 3 idle cycles between ack and next acia_rd; period 6 cycles.
//  5 reset asserted during ISSUE -> no ack, strobes 0 next cycle, next contested grant goes to A.
//  6 TXWAIT_EN, status bit1=0 for 4 polls then 1 -> 4+1 status reads, then 1 acia_wr, then a_ack.

Source files
------------

// File: rtl/acia_arbiter.sv
// Two-requester arbiter/sequencer in front of the single ACIA register port: one rd/wr strobe per req/ack.
// Optional TX-not-full polling before regSel 0 writes is enabled by defining ACIA_ARB_TXWAIT_EN.
module acia_arbiter #(
  parameter int          FIXED_PRIO = 0,
  parameter int unsigned GAP        = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_req,
  input  logic       a_wr,
  input  logic [1:0] a_regSel,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_wr,
  input  logic [1:0] b_regSel,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic [7:0] b_rdata,
  output logic       acia_rd,
  output logic       acia_wr,
  output logic [1:0] acia_regSel,
  output logic [7:0] acia_dataIn,
  input  logic [7:0] acia_dataOut
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE,
    S_GAP
`ifdef ACIA_ARB_TXWAIT_EN
    ,
    S_POLL,
    S_PCHK
`endif
  } state_t;

  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t     state, state_d;
  logic       cmd_wr, cmd_b, last_b;
  logic [1:0] cmd_regsel;
  logic [7:0] cmd_wdata;
  logic [3:0] gap_cnt;
  logic [7:0] a_rdata_q, b_rdata_q;
  logic       take, grant_b, sel_wr;
  logic [1:0] sel_regsel;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state;
    take        = 1'b0;
    acia_rd     = 1'b0;
    acia_wr     = 1'b0;
    acia_regSel = cmd_regsel;
    a_ack       = 1'b0;
    b_ack       = 1'b0;
    // On a tie, round-robin favours whoever was not served last.
    if (a_req && b_req) grant_b = (FIXED_PRIO != 0) ? 1'b0 : !last_b;
    else                grant_b = b_req;
    sel_wr     = grant_b ? b_wr : a_wr;
    sel_regsel = grant_b ? b_regSel : a_regSel;

    case (state)
      S_IDLE: begin
        if (a_req || b_req) begin
          take = 1'b1;
`ifdef ACIA_ARB_TXWAIT_EN
          state_d = (sel_wr && sel_regsel == 2'd0) ? S_POLL : S_ISSUE;
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        acia_rd = !cmd_wr;
        acia_wr = cmd_wr;
        state_d = S_DONE;
      end
      S_DONE: begin
        a_ack   = !cmd_b;
        b_ack   = cmd_b;
        state_d = (GAP != 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = S_IDLE;
      end
`ifdef ACIA_ARB_TXWAIT_EN
      // Status register read; bit 1 set means the TX FIFO has room.
      S_POLL: begin
        acia_rd     = 1'b1;
        acia_regSel = 2'd1;
        state_d     = S_PCHK;
      end
      S_PCHK: begin
        state_d = acia_dataOut[1] ? S_ISSUE : S_POLL;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign acia_dataIn = cmd_wdata;
  // ACIA read data arrives the cycle after the strobe, i.e. alongside the ack.
  assign a_rdata = (a_ack && !cmd_wr) ? acia_dataOut : a_rdata_q;
  assign b_rdata = (b_ack && !cmd_wr) ? acia_dataOut : b_rdata_q;

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state      <= S_IDLE;
      cmd_wr     <= 1'b0;
      cmd_b      <= 1'b0;
      cmd_regsel <= 2'd0;
      cmd_wdata  <= 8'd0;
      last_b     <= 1'b1;
      gap_cnt    <= 4'd0;
      a_rdata_q  <= 8'd0;
      b_rdata_q  <= 8'd0;
    end else begin
      state <= state_d;
      if (take) begin
        cmd_wr     <= sel_wr;
        cmd_b      <= grant_b;
        cmd_regsel <= sel_regsel;
        cmd_wdata  <= grant_b ? b_wdata : a_wdata;
        last_b     <= grant_b;
      end
      gap_cnt <= (state == S_GAP) ? gap_cnt + 4'd1 : 4'd0;
      if (a_ack && !cmd_wr) a_rdata_q <= acia_dataOut;
      if (b_ack && !cmd_wr) b_rdata_q <= acia_dataOut;
    end
  end

endmodule
